fp_add_arbiter: RTL and testbench
=================================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter
Interface
REQ-001 SHALL have parameter ADDER_LAT, default 2: cycles the shared fp_adder needs from stable operands to a valid fp_result; legal 1..15.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each: requester i presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1 each: operation accepted when valid&&ready at a rising edge.
REQ-006 SHALL have ports req0_a/req0_b/req1_a/req1_b, input, 32 each: IEEE-754 single operands.
REQ-007 SHALL have ports req0_rmode/req1_rmode, input, 3 each: rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM).
REQ-008 SHALL have ports resp0_valid/resp1_valid, output, 1, and resp0_ready/resp1_ready, input, 1: result handshake per requester.
REQ-009 SHALL have ports resp0_result/resp1_result, output, 32, and resp0_flags/resp1_flags, output, 3: {err, overflow, underflow}.
REQ-010 SHALL have ports add_fp_a, add_fp_b, output, 32, and add_r_mode, output, 3: registered operands driven to the adder.
REQ-011 SHALL have ports add_fp_result, input, 32, and add_overflow/add_underflow, input, 1: adder outputs.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-014 SHALL, in IDLE, grant one valid requester combinationally; only the granted req_ready is high; both ready low outside IDLE.
REQ-015 SHALL arbitrate round-robin: if both valid, grant the requester not in last_grant; if one valid, grant it; last_grant updates on each acceptance.
REQ-016 SHALL, at acceptance edge E, latch a, b, rmode into add_* registers and the requester id into owner, and enter EXEC.
REQ-017 SHALL hold add_* stable from E until the next acceptance; requester inputs after E are ignored.
REQ-018 SHALL count ADDER_LAT cycles in EXEC with a 4-bit counter; at edge E+ADDER_LAT capture add_fp_result and flags into the response registers of owner and enter RESP.
REQ-019 SHALL assert resp_valid of owner only, from E+ADDER_LAT until a resp_valid&&resp_ready edge; result and flags stable meanwhile.
REQ-020 SHALL return to IDLE at the response handshake edge; no acceptance in that same cycle (minimum one-cycle bubble).
REQ-021 SHALL give minimum issue-to-issue spacing of ADDER_LAT+2 cycles with resp_ready held high.
REQ-022 SHALL keep err flag 0 for every adder-executed operation.
Reset
REQ-023 SHALL, on rst, immediately: state IDLE, counter 0, last_grant=1 (req0 wins first tie), owner 0, add_* 0, all resp_valid 0, results and flags 0, busy 0.
REQ-024 SHALL drop any in-flight operation on reset mid-EXEC or mid-RESP with no response ever issued for it.
Configuration
REQ-025 SHALL support macro FP_ADD_RMODE_CHECK_EN.
REQ-026 SHALL, with FP_ADD_RMODE_CHECK_EN defined, treat rmode 101..111 as illegal: accept it, skip EXEC, enter RESP at E+1 with result 32'h7FC00000, flags 3'b100, add_* unchanged.
REQ-027 SHALL, without FP_ADD_RMODE_CHECK_EN, pass every rmode to the adder unchecked; err flag constant 0.
Verification
REQ-028 SHALL cover: ADDER_LAT=2, req0 a=3F800000 b=3F800000 rmode 000 at E -> resp0_valid at E+2, resp0_result 40000000, flags 000, resp1_valid 0.
REQ-029 SHALL cover: both valid in first IDLE after reset -> req0 granted first; both held valid -> grants alternate 0,1,0,1.
REQ-030 SHALL cover: resp_ready low 5 cycles in RESP -> resp_valid, result stable; both req_ready low; busy 1.
REQ-031 SHALL cover: rst asserted in EXEC -> outputs reset same cycle, no resp_valid after release, next request serviced normally.
REQ-032 SHALL cover: req1 a=7F7FFFFF b=7F7FFFFF rmode 000 -> resp1_flags 010 mirroring adder overflow.
REQ-033 SHALL cover: with FP_ADD_RMODE_CHECK_EN, rmode 111 at E -> resp_valid at E+1, result 7FC00000, flags 100; without macro -> adder path, err 0.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: two-requester round-robin front end for one shared,
// fixed-latency IEEE-754 single-precision adder. One operation is in flight
// at a time: IDLE grants and latches operands, EXEC waits ADDER_LAT cycles,
// RESP holds the result for the owning requester until it is taken.
//
// Optional feature: define FP_ADD_RMODE_CHECK_EN to reject rounding modes
// 101..111. Such operations are still accepted but bypass the adder and
// answer one cycle later with a quiet NaN (32'h7FC00000) and err set.
// With the macro undefined every rounding mode goes to the adder and the
// err flag is always 0.

module fp_add_arbiter #(
    parameter int unsigned ADDER_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_rmode,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_rmode,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,
    output logic [2:0]  resp0_flags,

    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,
    output logic [2:0]  resp1_flags,

    output logic [31:0] add_fp_a,
    output logic [31:0] add_fp_b,
    output logic [2:0]  add_r_mode,
    input  logic [31:0] add_fp_result,
    input  logic        add_overflow,
    input  logic        add_underflow,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]  LAT_LAST = 4'(ADDER_LAT - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       add_a_q, add_a_d;
    logic [31:0]       add_b_q, add_b_d;
    logic [2:0]        add_rm_q, add_rm_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [1:0][31:0]  resp_result_q, resp_result_d;
    logic [1:0][2:0]   resp_flags_q, resp_flags_d;

    logic              grant_id;
    logic              accept;
    logic [31:0]       sel_a, sel_b;
    logic [2:0]        sel_rmode;
    logic              sel_bad;
    logic              owner_ready;

    // Round-robin grant: on a tie the requester that did not win last time goes.
    always_comb begin
        grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
        accept    = (state_q == IDLE) && (req0_valid || req1_valid);
        sel_a     = grant_id ? req1_a     : req0_a;
        sel_b     = grant_id ? req1_b     : req0_b;
        sel_rmode = grant_id ? req1_rmode : req0_rmode;
    end

`ifdef FP_ADD_RMODE_CHECK_EN
    assign sel_bad = (sel_rmode > 3'd4);
`else
    assign sel_bad = 1'b0;
`endif

    assign req0_ready  = accept && !grant_id;
    assign req1_ready  = accept &&  grant_id;
    assign owner_ready = owner_q ? resp1_ready : resp0_ready;

    // Next-state and datapath-register update for the IDLE/EXEC/RESP sequence.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves one unassigned (no latches).
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        illegal_d     = illegal_q;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        add_rm_d      = add_rm_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = grant_id;
                    owner_d      = grant_id;
                    illegal_d    = sel_bad;
                    cnt_d        = 4'd0;
                    state_d      = EXEC;
                    // A rejected rounding mode never reaches the adder, so its
                    // operands stay as they were.
                    if (!sel_bad) begin
                        add_a_d  = sel_a;
                        add_b_d  = sel_b;
                        add_rm_d = sel_rmode;
                    end
                end
            end

            EXEC: begin
                if (illegal_q) begin
                    resp_result_d[owner_q] = QNAN;
                    resp_flags_d[owner_q]  = 3'b100;
                    resp_valid_d[owner_q]  = 1'b1;
                    state_d                = RESP;
                end else if (cnt_q == LAT_LAST) begin
                    resp_result_d[owner_q] = add_fp_result;
                    resp_flags_d[owner_q]  = {1'b0, add_overflow, add_underflow};
                    resp_valid_d[owner_q]  = 1'b1;
                    state_d                = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            RESP: begin
                // Back to IDLE on the handshake; the grant logic only looks at
                // IDLE, which guarantees the one-cycle bubble.
                if (resp_valid_q[owner_q] && owner_ready) begin
                    resp_valid_d = 2'b00;
                    state_d      = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset; an in-flight operation is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            illegal_q     <= 1'b0;
            add_a_q       <= 32'd0;
            add_b_q       <= 32'd0;
            add_rm_q      <= 3'd0;
            resp_valid_q  <= 2'b00;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            illegal_q     <= illegal_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            add_rm_q      <= add_rm_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
        end
    end

    assign add_fp_a     = add_a_q;
    assign add_fp_b     = add_b_q;
    assign add_r_mode   = add_rm_q;
    assign resp0_valid  = resp_valid_q[0];
    assign resp1_valid  = resp_valid_q[1];
    assign resp0_result = resp_result_q[0];
    assign resp1_result = resp_result_q[1];
    assign resp0_flags  = resp_flags_q[0];
    assign resp1_flags  = resp_flags_q[1];
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter. A stand-in adder produces a valid sum only
// after its operands have been stable for ADDER_LAT cycles; a driver issues
// directed and random operations and pushes the expected response into a
// scoreboard queue; a monitor pops and compares whenever a response appears.

module tb_fp_add_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_rmode, req1_rmode;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic [2:0]  resp0_flags, resp1_flags;
    logic [31:0] add_fp_a, add_fp_b, add_fp_result;
    logic [2:0]  add_r_mode;
    logic        add_overflow, add_underflow;
    logic        busy;

    fp_add_arbiter #(.ADDER_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_rmode(req0_rmode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_rmode(req1_rmode),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_flags(resp0_flags),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_flags(resp1_flags),
        .add_fp_a(add_fp_a), .add_fp_b(add_fp_b), .add_r_mode(add_r_mode),
        .add_fp_result(add_fp_result), .add_overflow(add_overflow),
        .add_underflow(add_underflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Stand-in adder arithmetic: equal normal operands double exactly
    // (exponent + 1, overflowing to infinity); anything else gets a scrambled
    // pattern that still depends on the rounding mode.
    function automatic logic [33:0] fake_add(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] rm);
        logic [7:0]  e;
        logic [31:0] r;
        logic        ovf, unf;
        ovf = 1'b0;
        unf = 1'b0;
        if (a == b && a[30:23] != 8'h00 && a[30:23] != 8'hFF) begin
            e = a[30:23] + 8'd1;
            if (e == 8'hFF) begin
                r   = {a[31], 8'hFF, 23'h0};
                ovf = 1'b1;
            end else begin
                r = {a[31], e, a[22:0]};
            end
        end else begin
            r   = a ^ {b[15:0], b[31:16]} ^ {29'h0, rm};
            unf = (r[30:23] == 8'h00);
        end
        return {ovf, unf, r};
    endfunction

    // Adder timing: outputs are garbage until operands have been stable L cycles.
    int          stable = 0;
    logic [66:0] prev_ops = '0;
    logic [33:0] sum;
    initial forever begin
        @(posedge clk);
        #1;
        if ({add_fp_a, add_fp_b, add_r_mode} != prev_ops) begin
            prev_ops = {add_fp_a, add_fp_b, add_r_mode};
            stable   = 0;
        end else if (stable < 100) begin
            stable++;
        end
    end
    assign sum           = fake_add(add_fp_a, add_fp_b, add_r_mode);
    assign add_fp_result = (stable >= L - 1) ? sum[31:0] : 32'hDEAD_BEEF;
    assign add_overflow  = (stable >= L - 1) ? sum[33]   : 1'b1;
    assign add_underflow = (stable >= L - 1) ? sum[32]   : 1'b1;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [2:0]  flags;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic        model_last = 1'b1;
    logic [31:0] ea = '0, eb = '0;
    logic [2:0]  erm = '0;
    bit          first_resp = 1'b1;

    // Drive one operation from a negedge, wait for its acceptance, predict.
    task automatic issue(input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] rm0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] rm1);
        logic        g, bad;
        logic [31:0] a, b;
        logic [2:0]  rm;
        logic [33:0] s;
        exp_t        e;
        int          waited;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_rmode = rm0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_rmode = rm1;
        waited = 0;
        #1;
        while (!(req0_ready || req1_ready)) begin
            if (waited == 64) begin
                $display("FAIL accept_timeout: no req_ready within 64 cycles");
                $fatal(1, "stopping");
            end
            @(negedge clk);
            #1;
            waited++;
        end
        g = (v0 && v1) ? ~model_last : ~v0;
        check("grant", {62'd0, req1_ready, req0_ready}, g ? 64'd2 : 64'd1);
        check("busy_idle", {63'd0, busy}, 64'd0);
        model_last = g;
        a  = g ? a1 : a0;
        b  = g ? b1 : b0;
        rm = g ? rm1 : rm0;
`ifdef FP_ADD_RMODE_CHECK_EN
        bad = (rm > 3'd4);
`else
        bad = 1'b0;
`endif
        e.id = g;
        if (bad) begin
            e.res   = 32'h7FC0_0000;
            e.flags = 3'b100;
            e.due   = cyc + 2;
        end else begin
            s       = fake_add(a, b, rm);
            e.res   = s[31:0];
            e.flags = {1'b0, s[33], s[32]};
            e.due   = cyc + 1 + L;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!bad) begin
            ea = a; eb = b; erm = rm;
        end
        // Requesters stay valid with fresh payload; the DUT must ignore it.
        req0_a = $urandom; req0_b = $urandom; req0_rmode = 3'($urandom_range(0, 7));
        req1_a = $urandom; req1_b = $urandom; req1_rmode = 3'($urandom_range(0, 7));
    endtask

    // Monitor: pop on each new response, hold it for a random stall, check.
    initial begin
        bit   active;
        int   stall;
        exp_t cur;
        active = 1'b0;
        stall  = 0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                active = 1'b0;
                resp0_ready = 1'b0;
                resp1_ready = 1'b0;
                continue;
            end
            check("add_hold", {add_fp_a, add_fp_b}, {ea, eb});
            check("add_rmode_hold", {61'd0, add_r_mode}, {61'd0, erm});
            if (!active && (resp0_valid || resp1_valid)) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", {62'd0, resp1_valid, resp0_valid}, 64'd0);
                end else begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                    stall  = first_resp ? 5 : $urandom_range(0, 3);
                    first_resp = 1'b0;
                    check("resp_cycle", 64'(cyc), 64'(cur.due));
                    check("resp_result", cur.id ? resp1_result : resp0_result, cur.res);
                    check("resp_flags", {61'd0, cur.id ? resp1_flags : resp0_flags},
                          {61'd0, cur.flags});
                end
            end
            if (active) begin
                check("resp_owner_only", {62'd0, resp1_valid, resp0_valid},
                      cur.id ? 64'd2 : 64'd1);
                check("resp_stable", {29'd0, cur.id ? resp1_flags : resp0_flags,
                                      cur.id ? resp1_result : resp0_result},
                      {29'd0, cur.flags, cur.res});
                check("resp_side", {61'd0, req1_ready, req0_ready, busy}, 64'd1);
                if (stall == 0) begin
                    resp0_ready = 1'b1;
                    resp1_ready = 1'b1;
                    active = 1'b0;
                end else begin
                    stall--;
                    resp0_ready = 1'b0;
                    resp1_ready = 1'b0;
                end
            end else begin
                resp0_ready = 1'b0;
                resp1_ready = 1'b0;
            end
        end
    end

    initial begin
        int          waited;
        logic [31:0] a;
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_rmode = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_rmode = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_resp_valid", {62'd0, resp1_valid, resp0_valid}, 64'd0);
        check("reset_results", {resp1_result, resp0_result}, 64'd0);
        check("reset_flags_add", {29'd0, resp1_flags, resp0_flags, add_r_mode, add_fp_a[22:0]}, 64'd0);
        check("reset_add_ops", {add_fp_a, add_fp_b}, 64'd0);
        check("reset_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Tie right after reset goes to req0; held ties alternate 0,1,0,1.
        // 1.0 + 1.0 = 2.0 on req0, FLT_MAX + FLT_MAX overflows on req1.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue(1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 3'b000,
                  32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b000);
        end

        // Rounding mode 111 from req1 only.
        @(negedge clk);
        issue(1'b0, 1'b1, '0, '0, 3'b000, 32'h4040_0000, 32'h3F00_0000, 3'b111);

        // Reset while the next operation is in EXEC; nothing may come back.
        @(negedge clk);
        issue(1'b1, 1'b0, 32'h4110_0000, 32'h4000_0000, 3'b001, '0, '0, 3'b000);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        ea = '0; eb = '0; erm = '0;
        sb.delete();
        model_last = 1'b1;
        #1;
        check("midexec_reset_busy", {63'd0, busy}, 64'd0);
        check("midexec_reset_valid", {62'd0, resp1_valid, resp0_valid}, 64'd0);
        check("midexec_reset_add", {add_fp_a, add_fp_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Serviced normally afterwards, tie goes to req0 again.
        issue(1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 3'b000,
              32'h4000_0000, 32'h4000_0000, 3'b000);

        // Random traffic with occasional idle gaps and illegal rounding modes.
        for (int i = 0; i < 60; i++) begin
            int   pat;
            logic [2:0] rm0, rm1;
            logic [31:0] a1;
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            pat = $urandom_range(1, 3);
            rm0 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            rm1 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            a   = $urandom;
            a1  = $urandom;
            issue(pat[0], pat[1],
                  a, ($urandom_range(0, 2) == 0) ? a : 32'($urandom), rm0,
                  a1, ($urandom_range(0, 2) == 0) ? a1 : 32'($urandom), rm1);
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waited = 0;
        while ((sb.size() != 0 || busy) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
